mips_register_file_mp: RTL and testbench

Parametrised multi-read-port register file for MIPS-based cores. It generalises the existing single-configuration register file with the following:
- configurable depth, data width and read-port count;
- a synchronous reset that sweeps every entry to zero;
- a `ready` status output;
- an optional per-register pending-write scoreboard for pipeline hazard detection.

It sits between the decode stage (read ports) and the writeback stage (write port).

---
 rtl/mips_register_file_mp.sv | 77 +++++++
 tb/tb_mips_register_file_mp.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mips_register_file_mp.sv
// mips_register_file_mp: multi-read-port register file with post-reset clear sweep; RF_SCOREBOARD_EN adds a pending-write scoreboard
module mips_register_file_mp #(
  parameter int AWL = 5,
  parameter int DWL = 32,
  parameter int NUM_RD = 2,
  parameter int RF_MODE = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [AWL-1:0]        WA,
  input  logic [DWL-1:0]        WD,
  input  logic [NUM_RD*AWL-1:0] RA,
  output logic [NUM_RD*DWL-1:0] RD,
  output logic                  ready
`ifdef RF_SCOREBOARD_EN
  ,
  input  logic                  res_en,
  input  logic [AWL-1:0]        res_addr,
  output logic [NUM_RD-1:0]     pend
`endif
);
  localparam int DEPTH = 2**AWL;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [AWL-1:0] ptr;
  logic [DWL-1:0] rf [DEPTH];
  logic clr, we;
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= state_n;
      ptr <= clr ? ptr + AWL'(1) : ptr;
    end
  always_comb state_n = (clr && &ptr) ? RUN : state;
  always_comb begin
    clr = state == CLEAR;
    ready = state == RUN;
    we = ready && wen && !(ZERO_REG != 0 && WA == '0);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      if (clr) rf[ptr] <= '0;
      else if (we) rf[WA] <= WD;
    end
`ifdef RF_SCOREBOARD_EN
  logic [DEPTH-1:0] pbit;
  // set after clear so a same-cycle reserve of the written register wins
  always_ff @(posedge clk)
    if (rst) pbit <= '0;
    else if (ready) begin
      if (we) pbit[WA] <= 1'b0;
      if (res_en && !(ZERO_REG != 0 && res_addr == '0)) pbit[res_addr] <= 1'b1;
    end
`endif
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AWL-1:0] ra;
    logic zr;
    assign ra = RA[i*AWL +: AWL];
    assign zr = ZERO_REG != 0 && ra == '0;
`ifdef RF_SCOREBOARD_EN
    assign pend[i] = pbit[ra];
`endif
    if (RF_MODE == 0) begin : g_async
      assign RD[i*DWL +: DWL] = (clr || zr) ? '0 : rf[ra];
    end else begin : g_sync
      logic [DWL-1:0] rd_q;
      always_ff @(posedge clk)
        if (rst || clr || zr) rd_q <= '0;
        else rd_q <= (RF_MODE == 1 && we && WA == ra) ? WD : rf[ra];
      assign RD[i*DWL +: DWL] = rd_q;
    end
  end
endmodule

// File: tb/tb_mips_register_file_mp.sv
// tb_mips_register_file_mp: checks all three read modes side by side against a behavioural register-file model
module tb_mips_register_file_mp;
  logic clk = 0, rst = 1, wen = 0, res_en = 0, chk = 0;
  logic [4:0] WA = 0, res_addr = 0;
  logic [31:0] WD = 0;
  logic [4:0] ra [2] = '{5'd0, 5'd0};
  logic [9:0] RA;
  logic [63:0] rd_m [3];
  logic [2:0] rdy;
  logic [1:0] pnd [3];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign RA = {ra[1], ra[0]};
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_register_file_mp #(.RF_MODE(g)) u (
      .clk(clk), .rst(rst), .wen(wen), .WA(WA), .WD(WD), .RA(RA), .RD(rd_m[g]), .ready(rdy[g])
`ifdef RF_SCOREBOARD_EN
      , .res_en(res_en), .res_addr(res_addr), .pend(pnd[g])
`endif
    );
  end
  logic [31:0] mem [32];
  logic [31:0] e1 [2], e2 [2];
  logic [31:0] pb;
  int cnt;
  logic m_ready;
  // model: 32 edges of clearing after reset, then reads see pre-write (mode 2) or bypassed (mode 1) data
  always @(posedge clk) begin
    if (rst) begin
      chk <= 1;
      cnt <= 0;
      m_ready <= 0;
      pb <= '0;
      for (int p = 0; p < 2; p++) begin e1[p] <= 0; e2[p] <= 0; end
    end else if (!m_ready) begin
      mem[cnt] <= 0;
      cnt <= cnt + 1;
      m_ready <= cnt == 31;
      for (int p = 0; p < 2; p++) begin e1[p] <= 0; e2[p] <= 0; end
    end else begin
      for (int p = 0; p < 2; p++) begin
        e2[p] <= ra[p] == 0 ? 0 : mem[ra[p]];
        e1[p] <= ra[p] == 0 ? 0 : (wen && WA == ra[p]) ? WD : mem[ra[p]];
      end
      if (wen && WA != 0) begin mem[WA] <= WD; pb[WA] <= 0; end
      if (res_en && res_addr != 0) pb[res_addr] <= 1;
    end
  end
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] rdv(int m, int p);
    return rd_m[m][p*32 +: 32];
  endfunction
  always @(negedge clk)
    if (chk)
      for (int m = 0; m < 3; m++) begin
        check($sformatf("ready m%0d", m), {31'b0, rdy[m]}, {31'b0, m_ready});
        for (int p = 0; p < 2; p++) begin
          check($sformatf("RD m%0d p%0d a%0d", m, p, ra[p]), rdv(m, p),
                m == 0 ? ((m_ready && ra[p] != 0) ? mem[ra[p]] : 32'h0) : m == 1 ? e1[p] : e2[p]);
`ifdef RF_SCOREBOARD_EN
          check($sformatf("pend m%0d p%0d a%0d", m, p, ra[p]), {31'b0, pnd[m][p]}, {31'b0, pb[ra[p]]});
`endif
        end
      end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    tick(2);
    rst = 0;
    wen = 1; WA = 3; WD = 32'hDEAD; ra[0] = 3;
    tick(10);
    rst = 1;
    tick(1);
    rst = 0;
    tick(31);
    for (int m = 0; m < 3; m++) check("ready after 31", {29'b0, rdy}, 32'h0);
    wen = 0;
    tick(1);
    check("ready after 32", {29'b0, rdy}, 32'h7);
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(31 - a);
      #1 check("swept entry", rdv(0, 0) | rdv(0, 1), 32'h0);
    end
    ra[0] = 3;
    #1 check("write in clear dropped", rdv(0, 0), 32'h0);
    wen = 1; WA = 5; WD = 32'h1111;
    tick(1);
    ra[0] = 5; ra[1] = 5; WD = 32'h1234;
    tick(1);
    wen = 0;
    check("m0 p0 new", rdv(0, 0), 32'h1234);
    check("m0 p1 new", rdv(0, 1), 32'h1234);
    check("m1 p0 bypass", rdv(1, 0), 32'h1234);
    check("m1 p1 bypass", rdv(1, 1), 32'h1234);
    check("m2 p0 old", rdv(2, 0), 32'h1111);
    check("m2 p1 old", rdv(2, 1), 32'h1111);
    tick(1);
    check("m2 p0 new", rdv(2, 0), 32'h1234);
    wen = 1; WA = 0; WD = 32'hFFFFFFFF; ra[0] = 0; ra[1] = 0; res_en = 1; res_addr = 0;
    tick(1);
    wen = 0; res_en = 0;
    tick(1);
    for (int m = 0; m < 3; m++) check($sformatf("zero reg m%0d", m), rdv(m, 0), 32'h0);
`ifdef RF_SCOREBOARD_EN
    check("pend zero reg", {30'b0, pnd[0]}, 32'h0);
    res_en = 1; res_addr = 7; ra[0] = 7; ra[1] = 7;
    tick(1);
    res_en = 0;
    check("pend set", {31'b0, pnd[0][0]}, 32'h1);
    wen = 1; WA = 7; WD = 32'h7777;
    tick(1);
    wen = 0;
    check("pend cleared", {31'b0, pnd[0][0]}, 32'h0);
    wen = 1; res_en = 1; WD = 32'h7878;
    tick(1);
    wen = 0; res_en = 0;
    check("pend new producer wins", {31'b0, pnd[0][0]}, 32'h1);
`endif
    for (int i = 0; i < 20; i++) begin
      ra[0] = WA;
      wen = 1; WA = 5'((i * 7 + 1) % 32); WD = 32'hA5000000 + i * 32'h10101;
      ra[1] = WA;
      res_en = i[0]; res_addr = 5'((i * 3) % 32);
      tick(1);
    end
    wen = 0; res_en = 0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
